// File: rtl/lane_deskew_buffer_if.sv
// lane_deskew_buffer_if
//   Bundles the lane-side and output-side signals of lane_deskew_buffer.
//   Signals:
//     data_in      LANES*DATA_WIDTH  lane i symbol at [i*DATA_WIDTH +: DATA_WIDTH]
//     valid_in     LANES             per-lane write enable
//     data_out     LANES*DATA_WIDTH  deskewed symbols, same packing
//     valid_out    1                 data_out valid on all lanes together
//     aligned      1                 high while lanes are locked to a common COM
//     deskew_error 1                 one-cycle pulse on skew timeout or marker mismatch
//     overflow     LANES             one-cycle pulse when a write hit a full lane FIFO
//   master: the source of lane symbols (drives data_in/valid_in)
//   slave:  the deskew buffer itself
interface lane_deskew_buffer_if #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 10
);
    logic [LANES*DATA_WIDTH-1:0] data_in;
    logic [LANES-1:0]            valid_in;
    logic [LANES*DATA_WIDTH-1:0] data_out;
    logic                        valid_out;
    logic                        aligned;
    logic                        deskew_error;
    logic [LANES-1:0]            overflow;

    modport master (
        output data_in, valid_in,
        input  data_out, valid_out, aligned, deskew_error, overflow
    );

    modport slave (
        input  data_in, valid_in,
        output data_out, valid_out, aligned, deskew_error, overflow
    );
endinterface

// File: rtl/lane_deskew_buffer.sv
// lane_deskew_buffer
//   Per-lane FIFOs that discard symbols until every lane shows a COM symbol at its
//   head, then release all lanes in lock-step. Loss of alignment (a pop where only
//   some lanes carry COM), a skew window that runs out, or a write into a full lane
//   FIFO flushes every FIFO and returns to searching.
//   Ports:
//     clock  single clock
//     reset  synchronous, active-high; clears pointers, state and all outputs
//     bus    lane_deskew_buffer_if.slave (data_in/valid_in in; data_out, valid_out,
//            aligned, deskew_error, overflow out -- all outputs registered)
module lane_deskew_buffer #(
    parameter int LANES         = 4,
    parameter int DATA_WIDTH    = 10,
    parameter int BUFFER_DEPTH  = 16,
    parameter int ADDRESS_WIDTH = 4,
    parameter int MAX_SKEW      = 8,
    parameter logic [DATA_WIDTH-1:0] COM_NEG = 10'b0011111010,
    parameter logic [DATA_WIDTH-1:0] COM_POS = 10'b1100000101
) (
    input logic                clock,
    input logic                reset,
    lane_deskew_buffer_if.slave bus
);
    localparam int PTR_W  = ADDRESS_WIDTH + 1;
    localparam int SKEW_W = $clog2(MAX_SKEW + 1);

    typedef enum logic {SEARCH, ALIGNED} state_t;

    function automatic logic [SKEW_W-1:0] sat_inc(input logic [SKEW_W-1:0] v);
        return (v == SKEW_W'(MAX_SKEW)) ? v : v + SKEW_W'(1);
    endfunction

    logic [DATA_WIDTH-1:0] mem    [LANES][BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr [LANES];
    logic [PTR_W-1:0]      rd_ptr [LANES];
    logic [DATA_WIDTH-1:0] head   [LANES];

    logic [LANES-1:0] empty, full, head_com, lane_ovf, pop;
    logic             flush, mismatch, timeout, emit;
    state_t           state, state_next;
    logic [SKEW_W-1:0] skew_count, skew_next;

    logic [LANES*DATA_WIDTH-1:0] data_out_p1;
    logic                        vld_p1;
    logic                        aligned_p1;
    logic                        err_p1;
    logic [LANES-1:0]            ovf_p1;

    always_comb begin
        empty    = '0;
        full     = '0;
        head_com = '0;
        lane_ovf = '0;
        for (int i = 0; i < LANES; i++) begin
            head[i]     = mem[i][rd_ptr[i][ADDRESS_WIDTH-1:0]];
            empty[i]    = (wr_ptr[i] == rd_ptr[i]);
            // Same slot, opposite lap: the FIFO holds BUFFER_DEPTH entries.
            full[i]     = (wr_ptr[i][ADDRESS_WIDTH] != rd_ptr[i][ADDRESS_WIDTH]) &&
                          (wr_ptr[i][ADDRESS_WIDTH-1:0] == rd_ptr[i][ADDRESS_WIDTH-1:0]);
            head_com[i] = !empty[i] && (head[i] == COM_NEG || head[i] == COM_POS);
            lane_ovf[i] = bus.valid_in[i] && full[i];
        end
    end

    always_comb begin
        pop        = '0;
        mismatch   = 1'b0;
        timeout    = 1'b0;
        emit       = 1'b0;
        state_next = state;
        skew_next  = skew_count;
        case (state)
            SEARCH: begin
                if (&head_com) begin
                    state_next = ALIGNED;
                    skew_next  = '0;
                end else if (skew_count == SKEW_W'(MAX_SKEW)) begin
                    timeout = 1'b1;
                end else begin
                    // Lanes already showing COM wait; the rest discard until they do.
                    if (|head_com) skew_next = sat_inc(skew_count);
                    pop = ~empty & ~head_com;
                end
            end
            ALIGNED: begin
                // Lanes only ever advance together, so a lane that runs dry stalls all.
                if (&(~empty)) begin
                    if ((|head_com) && !(&head_com)) begin
                        mismatch = 1'b1;
                    end else if (!(|lane_ovf)) begin
                        emit = 1'b1;
                        pop  = '1;
                    end
                end
            end
            default: state_next = SEARCH;
        endcase
        flush = (|lane_ovf) || mismatch || timeout;
        if (flush) begin
            state_next = SEARCH;
            skew_next  = '0;
        end
    end

    // Stage 1: control state, FIFO pointers and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= SEARCH;
            skew_count  <= '0;
            data_out_p1 <= '0;
            vld_p1      <= 1'b0;
            aligned_p1  <= 1'b0;
            err_p1      <= 1'b0;
            ovf_p1      <= '0;
            for (int i = 0; i < LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            state      <= state_next;
            skew_count <= skew_next;
            vld_p1     <= emit;
            aligned_p1 <= (state_next == ALIGNED);
            err_p1     <= mismatch || timeout;
            ovf_p1     <= lane_ovf;
            for (int i = 0; i < LANES; i++) begin
                if (emit) data_out_p1[i*DATA_WIDTH +: DATA_WIDTH] <= head[i];
                if (flush) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                end else begin
                    if (pop[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                    if (bus.valid_in[i] && !full[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
            end
        end
    end

    // Symbol storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (!reset && !flush && bus.valid_in[i] && !full[i])
                mem[i][wr_ptr[i][ADDRESS_WIDTH-1:0]] <= bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.data_out     = data_out_p1;
    assign bus.valid_out    = vld_p1;
    assign bus.aligned      = aligned_p1;
    assign bus.deskew_error = err_p1;
    assign bus.overflow     = ovf_p1;
endmodule

// File: tb/tb_lane_deskew_buffer.sv
`timescale 1ns/1ps
module tb_lane_deskew_buffer;
    localparam int LANES    = 4;
    localparam int DW       = 10;
    localparam int DEPTH    = 16;
    localparam int MAX_SKEW = 8;
    localparam logic [DW-1:0] COM_N = 10'b0011111010;
    localparam logic [DW-1:0] COM_P = 10'b1100000101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lane_deskew_buffer_if #(.LANES(LANES), .DATA_WIDTH(DW)) bus ();
    lane_deskew_buffer_if #(.LANES(1), .DATA_WIDTH(DW)) bus1 ();

    lane_deskew_buffer #(
        .LANES(LANES), .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .ADDRESS_WIDTH(4),
        .MAX_SKEW(MAX_SKEW), .COM_NEG(COM_N), .COM_POS(COM_P)
    ) dut (.clock(clk), .reset(rst), .bus(bus));

    lane_deskew_buffer #(
        .LANES(1), .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .ADDRESS_WIDTH(4),
        .MAX_SKEW(MAX_SKEW), .COM_NEG(COM_N), .COM_POS(COM_P)
    ) dut1 (.clock(clk), .reset(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;

    // Reference model: one queue of symbols per lane plus a locked flag.
    logic [DW-1:0] q [LANES][$];
    bit   m_al;
    int   m_skew;
    logic [LANES*DW-1:0] e_data;
    bit   e_valid, e_al, e_err;
    logic [LANES-1:0] e_ovf;

    int  err_pulses;
    int  ovf_pulses [LANES];
    bit  seen_first;
    int  offs [LANES];

    function automatic bit is_com(input logic [DW-1:0] s);
        return (s == COM_N) || (s == COM_P);
    endfunction

    function automatic logic [DW-1:0] rand_sym();
        logic [DW-1:0] s;
        s = DW'($urandom);
        while (is_com(s)) s = DW'($urandom);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [LANES*DW-1:0] d, input logic [LANES-1:0] v, input bit r);
        bit hc [LANES];
        bit all_hc, any_hc, all_ne, flush;
        logic [LANES-1:0] popm;
        if (r) begin
            for (int i = 0; i < LANES; i++) q[i].delete();
            m_al = 0; m_skew = 0;
            e_data = '0; e_valid = 0; e_al = 0; e_err = 0; e_ovf = '0;
            return;
        end
        all_hc = 1; any_hc = 0; all_ne = 1; e_ovf = '0;
        for (int i = 0; i < LANES; i++) begin
            hc[i]    = (q[i].size() > 0) && is_com(q[i][0]);
            all_hc   = all_hc && hc[i];
            any_hc   = any_hc || hc[i];
            all_ne   = all_ne && (q[i].size() > 0);
            e_ovf[i] = v[i] && (q[i].size() == DEPTH);
        end
        flush = |e_ovf; e_err = 0; e_valid = 0; popm = '0;
        if (!m_al) begin
            if (all_hc) begin
                m_al = 1; m_skew = 0;
            end else if (m_skew == MAX_SKEW) begin
                e_err = 1; flush = 1;
            end else begin
                if (any_hc) m_skew = m_skew + 1;
                for (int i = 0; i < LANES; i++) popm[i] = (q[i].size() > 0) && !hc[i];
            end
        end else if (all_ne) begin
            if (any_hc && !all_hc) begin
                e_err = 1; flush = 1;
            end else if (!flush) begin
                e_valid = 1; popm = '1;
                for (int i = 0; i < LANES; i++) e_data[i*DW +: DW] = q[i][0];
            end
        end
        if (flush) begin
            for (int i = 0; i < LANES; i++) q[i].delete();
            m_al = 0; m_skew = 0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (popm[i]) void'(q[i].pop_front());
                if (v[i] && q[i].size() < DEPTH) q[i].push_back(d[i*DW +: DW]);
            end
        end
        e_al = m_al;
    endtask

    task automatic tick(input logic [LANES*DW-1:0] d, input logic [LANES-1:0] v, input bit r);
        bus.data_in = d; bus.valid_in = v; rst = r;
        model_step(d, v, r);
        @(posedge clk); #1;
        chk("valid_out", 64'(bus.valid_out), 64'(e_valid));
        chk("aligned", 64'(bus.aligned), 64'(e_al));
        chk("deskew_error", 64'(bus.deskew_error), 64'(e_err));
        chk("overflow", 64'(bus.overflow), 64'(e_ovf));
        chk("data_out", 64'(bus.data_out), 64'(e_data));
        if (bus.deskew_error) err_pulses++;
        for (int i = 0; i < LANES; i++) if (bus.overflow[i]) ovf_pulses[i]++;
        if (bus.valid_out && !seen_first) begin
            seen_first = 1;
            for (int i = 0; i < LANES; i++)
                chk("first_word_com", 64'(is_com(bus.data_out[i*DW +: DW])), 64'd1);
        end
    endtask

    // Lane i sends COM at cycles offs[i], offs[i]+period, ...; period 0 means no COM.
    task automatic run_stream(input int n, input int period, input logic [LANES-1:0] vmask,
                              input int drop_lane, input int drop_cyc);
        for (int c = 0; c < n; c++) begin
            logic [LANES*DW-1:0] d;
            logic [LANES-1:0] v;
            v = vmask;
            for (int i = 0; i < LANES; i++) begin
                if (period > 0 && c >= offs[i] && ((c - offs[i]) % period) == 0)
                    d[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? COM_N : COM_P;
                else
                    d[i*DW +: DW] = rand_sym();
                if (i == drop_lane && c == drop_cyc) v[i] = 1'b0;
            end
            tick(d, v, 1'b0);
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int c = 0; c < n; c++) tick('0, '0, r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] sym [6];
        logic [LANES*DW-1:0] rd;
        err_pulses = 0; seen_first = 0;
        for (int i = 0; i < LANES; i++) ovf_pulses[i] = 0;
        bus.data_in = '0; bus.valid_in = '0;
        bus1.data_in = '0; bus1.valid_in = '0;

        // Reset state
        idle(3, 1'b1);
        chk("reset_aligned", 64'(bus.aligned), 64'd0);
        chk("reset_data", 64'(bus.data_out), 64'd0);

        // Skews 0..3 with continuous data
        offs = '{0, 1, 2, 3};
        run_stream(60, 20, '1, -1, -1);
        chk("p1_aligned", 64'(bus.aligned), 64'd1);
        chk("p1_no_error", 64'(err_pulses), 64'd0);
        chk("p1_output_seen", 64'(seen_first), 64'd1);

        // Lane 3 COM nine cycles late: one timeout
        idle(2, 1'b1);
        err_pulses = 0;
        offs = '{0, 0, 0, 9};
        run_stream(40, 1000, '1, -1, -1);
        chk("p2_one_timeout", 64'(err_pulses), 64'd1);
        chk("p2_not_aligned", 64'(bus.aligned), 64'd0);

        // Skew of exactly MAX_SKEW still aligns
        err_pulses = 0; seen_first = 0;
        offs = '{0, 8, 3, 5};
        run_stream(60, 30, '1, -1, -1);
        chk("p2_realigned", 64'(bus.aligned), 64'd1);
        chk("p2_realign_no_error", 64'(err_pulses), 64'd0);

        // Lane 2 loses one symbol while aligned
        err_pulses = 0;
        run_stream(90, 30, '1, 2, 10);
        chk("p3_mismatch_seen", 64'(err_pulses > 0), 64'd1);
        chk("p3_realigned", 64'(bus.aligned), 64'd1);

        // Lane 0 overflow with other lanes idle
        idle(2, 1'b1);
        offs = '{0, 0, 0, 0};
        run_stream(20, 1000, '1, -1, -1);
        chk("p4_aligned", 64'(bus.aligned), 64'd1);
        idle(3, 1'b0);
        for (int i = 0; i < LANES; i++) ovf_pulses[i] = 0;
        run_stream(16, 0, 4'b0001, -1, -1);
        chk("p4_no_ovf_at_16", 64'(ovf_pulses[0]), 64'd0);
        run_stream(1, 0, 4'b0001, -1, -1);
        chk("p4_ovf_on_17th", 64'(bus.overflow), 64'd1);
        idle(2, 1'b0);
        chk("p4_ovf0_once", 64'(ovf_pulses[0]), 64'd1);
        for (int i = 1; i < LANES; i++) chk("p4_other_ovf", 64'(ovf_pulses[i]), 64'd0);
        chk("p4_search_after_ovf", 64'(bus.aligned), 64'd0);

        // Reset in the middle of an aligned stream
        offs = '{2, 0, 1, 3};
        run_stream(30, 15, '1, -1, -1);
        chk("p5_aligned", 64'(bus.aligned), 64'd1);
        for (int i = 0; i < LANES; i++) rd[i*DW +: DW] = rand_sym();
        tick(rd, '1, 1'b1);
        chk("p5_rst_aligned", 64'(bus.aligned), 64'd0);
        chk("p5_rst_valid", 64'(bus.valid_out), 64'd0);
        chk("p5_rst_data", 64'(bus.data_out), 64'd0);
        offs = '{1, 1, 0, 2};
        run_stream(30, 15, '1, -1, -1);
        chk("p5_realigned", 64'(bus.aligned), 64'd1);

        // Single-lane build
        bus.valid_in = '0;
        bus1.data_in = COM_P; bus1.valid_in = 1'b1;
        @(posedge clk); #1;
        chk("l1_not_yet_aligned", 64'(bus1.aligned), 64'd0);
        bus1.valid_in = 1'b0;
        @(posedge clk); #1;
        chk("l1_aligned", 64'(bus1.aligned), 64'd1);
        chk("l1_no_valid_yet", 64'(bus1.valid_out), 64'd0);
        for (int k = 0; k < 6; k++) begin
            sym[k] = rand_sym();
            bus1.data_in = sym[k]; bus1.valid_in = 1'b1;
            @(posedge clk); #1;
            chk("l1_valid", 64'(bus1.valid_out), 64'd1);
            if (k == 0) chk("l1_first_com", 64'(bus1.data_out), 64'(COM_P));
            else        chk("l1_data", 64'(bus1.data_out), 64'(sym[k-1]));
        end
        bus1.valid_in = 1'b0;
        @(posedge clk); #1;
        chk("l1_last_data", 64'(bus1.data_out), 64'(sym[5]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
